tile_blitter: RTL and testbench
===============================

Name: tile_blitter

Overview:
- Copies one TILE_W x TILE_H tile from the tile-source ROM into the 640x480 VGA frame memory at a requested screen position.
- Sits upstream of the frame-memory write arbiter and is one of its write producers, in parallel with the map and number writers.
- Replaces per-producer hand-written copy loops with a single start/busy/done engine.
- Skips transparent and off-screen pixels, and stalls cleanly under arbiter back-pressure.

Parameters:
- TILE_W, 32, tile width in pixels (power of two)
- TILE_H, 32, tile height in pixels (power of two)
- SCREEN_W, 640, frame width in pixels, and the frame-memory row stride
- SCREEN_H, 480, frame height in pixels
- ADDR_W, 19, frame-memory and ROM address width
- DATA_W, 16, pixel width; bits [11:0] are RGB444
- TRANSP_BIT, 15, pixel bit that marks the pixel transparent when set

Ports:
- clk  in  1  system clock, 100 MHz
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  request pulse; sampled only in IDLE
- tile_id  in  8  tile index; latched on accepted start
- pos_x  in  10  screen x of the tile's top-left pixel; latched on accepted start
- pos_y  in  10  screen y of the tile's top-left pixel; latched on accepted start
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse when the blit completes
- src_addr  out  ADDR_W  tile ROM read address
- src_data  in  DATA_W  ROM read data, valid 1 cycle after src_addr
- dst_addr  out  ADDR_W  frame-memory write address
- dst_data  out  DATA_W  frame-memory write data
- dst_wr  out  1  write request
- dst_ready  in  1  arbiter accepts the write on this edge when dst_wr=1

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-low (rstn).
- Reset values: all outputs 0; FSM in IDLE; counters cleared.
  - Reset asserted mid-blit aborts immediately.
  - No done pulse is produced for the aborted blit.
  - No further dst_wr is issued after reset.
- FSM states:
  - IDLE: start=1 latches tile_id/pos_x/pos_y, sets busy=1, goes to RUN.
  - RUN: issues ROM reads for pixels 0..N-1, where N = TILE_W*TILE_H, in row-major order; goes to DRAIN after issuing pixel N-1.
  - DRAIN: waits until the last pixel's write is accepted or skipped.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy is ignored; it is neither queued nor re-latched.
- Source address: src_addr = tile_id*N + row*TILE_W + col. Use shift/concatenation only; no multiplier.
- Destination address: dst_addr = (pos_y+row)*SCREEN_W + (pos_x+col).
  - Computed incrementally: a row-base register is loaded with pos_y*SCREEN_W at start (constant shift-add 512+128) and advanced by SCREEN_W per row.
  - No runtime multiplier.
- Timing with dst_ready held at 1:
  - start is sampled at edge E0.
  - src_addr for pixel 0 is presented after E0.
  - dst outputs for pixel k are presented after E(k+2); the write is accepted at E(k+3).
  - done is high in the cycle following acceptance of the last pixel.
  - A full unclipped opaque tile therefore costs N+3 cycles, start to done.
- Write handshake:
  - dst_wr, dst_addr and dst_data are registered.
  - While dst_wr=1 and dst_ready=0, all three hold stable and ROM issue stops.
  - The one read already in flight is captured in a 1-entry skid register; no pixel is dropped or duplicated.
  - Issue resumes the cycle after the skid register drains.
- Suppressed pixels:
  - Pixels with src_data[TRANSP_BIT]=1 produce no dst_wr cycle.
  - Pixels with pos_x+col >= SCREEN_W or pos_y+row >= SCREEN_H produce no dst_wr cycle.
  - Suppressed pixels take no handshake and never stall.
  - Clip comparisons use 11-bit sums so that wrap-around cannot occur.
- Fully off-screen tile (pos_x>=SCREEN_W or pos_y>=SCREEN_H): the FSM still walks all N pixels with no writes, and done fires as in the normal case.
- dst_data is src_data passed through unchanged, including the TRANSP_BIT value.

Decomposition:
- Shared package fb_pkg holds:
  - SCREEN_W, SCREEN_H, ADDR_W, DATA_W, TRANSP_BIT
  - the frame address helper (y*SCREEN_W+x)
  - the FSM state encoding
- These are shared with the map, number and arbiter blocks.
- One natural sub-module: blit_skid_reg, the 1-entry output/skid buffer carrying valid/addr/data with ready back-pressure.

Test Plan:
1. Opaque tile: ROM model gives pixel=k, tile_id=0, pos=(0,0), dst_ready=1. Required: 1024 writes; write k at dst_addr = (k/32)*640 + k%32 with data k; done pulses exactly N+3 cycles after start; busy is low afterwards.
2. Transparency: tile_id=3 with every odd pixel having bit15=1. Required: src_addr starts at 3072; exactly 512 writes, all at even columns; no stall cycles added.
3. Clipping: pos=(624,472). Required: only 16x8=128 writes, the first at addr 472*640+624=302704; done still fires; no dst_addr >= 307200.
4. Back-pressure: dst_ready toggles with a pseudo-random 50% duty. Required: each pixel is written once, in order; outputs stay stable while stalled; write count is 1024.
5. start pulses at cycles 5 and 40 of an active blit. Required: both are ignored; the latched tile_id is unchanged; exactly one done.
6. rstn pulled low at pixel 300 of a blit. Required: outputs go to 0 asynchronously; no done pulse; a fresh start after release completes normally.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry, pixel format, blitter state encoding and
// the frame address helper shared by the frame-memory write producers.
package fb_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 16;
    localparam int TRANSP_BIT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    // y*SCREEN_W + x for the 640-wide frame, built as (y<<9)+(y<<7)+x so
    // that no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] frame_addr(input logic [10:0] y,
                                                     input logic [10:0] x);
        logic [ADDR_W-1:0] yw;
        yw = ADDR_W'(y);
        return (yw << 9) + (yw << 7) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/blit_skid_reg.sv
// blit_skid_reg: registered write-request stage with a single skid entry.
// The output register drives the arbiter directly; the skid entry catches
// the one ROM read that is already in flight when the arbiter stalls.
module blit_skid_reg #(
    parameter int AW = 19,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          room
);

    logic          skid_valid;
    logic [AW-1:0] skid_addr;
    logic [DW-1:0] skid_data;
    logic          out_free;

    // The output register is free when empty or being accepted this edge.
    assign out_free = !out_valid || out_ready;

    // A new read may be launched only when nothing is parked and the output
    // is moving; otherwise the read in flight would have nowhere to go.
    assign room = !skid_valid && out_free;

    // Output register advances from the skid entry first, then from the
    // pipeline; while stalled it holds and any arriving pixel is parked.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_addr   <= '0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_addr  <= '0;
            skid_data  <= '0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_addr   <= skid_addr;
                out_data   <= skid_data;
                skid_valid <= in_valid;
                if (in_valid) begin
                    skid_addr <= in_addr;
                    skid_data <= in_data;
                end
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    out_addr <= in_addr;
                    out_data <= in_data;
                end
            end
        end else if (in_valid) begin
            skid_valid <= 1'b1;
            skid_addr  <= in_addr;
            skid_data  <= in_data;
        end
    end

endmodule

// File: rtl/tile_blitter.sv
// tile_blitter: copies one TILE_W x TILE_H tile from the tile ROM into the
// 640x480 frame memory at (pos_x, pos_y), skipping transparent and
// off-screen pixels and honouring arbiter back-pressure.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; request fields latched on accept
//   ST_RUN   | presenting ROM addresses for pixels 0..N-1 in row-major order
//   ST_DRAIN | all reads launched; waiting for the pipeline to empty
//   ST_DONE  | one-cycle done pulse, busy low
//
// Pipeline: address stage (src_addr) -> read stage (ROM data returns,
// transparency/clip filter) -> blit_skid_reg (registered dst_* outputs).
module tile_blitter
    import fb_pkg::*;
#(
    parameter int TILE_W = 32,
    parameter int TILE_H = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [7:0]        tile_id,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] src_addr,
    input  logic [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0] dst_addr,
    output logic [DATA_W-1:0] dst_data,
    output logic              dst_wr,
    input  logic              dst_ready
);

    localparam int N     = TILE_W * TILE_H;
    localparam int COL_W = $clog2(TILE_W);
    localparam int ROW_W = $clog2(TILE_H);
    localparam int PIX_W = COL_W + ROW_W;

    blit_state_t       state_q, state_d;
    logic              accept;

    logic [7:0]        tile_q;
    logic [9:0]        pos_x_q;
    logic [9:0]        pos_y_q;
    logic [PIX_W-1:0]  pix_q;
    logic              a_valid_q;
    logic [ADDR_W-1:0] row_base_q;

    logic              rd_valid_q;
    logic [ADDR_W-1:0] rd_dst_q;
    logic              rd_clip_q;

    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [10:0]       x_sum;
    logic [10:0]       y_sum;
    logic              a_clip;
    logic [ADDR_W-1:0] a_dst;
    logic              last_pix;
    logic              end_of_row;
    logic              issue;
    logic              room;
    logic              wr_valid;

    assign col        = pix_q[COL_W-1:0];
    assign row        = pix_q[PIX_W-1:COL_W];
    assign last_pix   = (pix_q == PIX_W'(N - 1));
    assign end_of_row = (col == COL_W'(TILE_W - 1));

    // 11-bit sums: a 10-bit position plus a tile offset cannot wrap here.
    assign x_sum  = {1'b0, pos_x_q} + 11'(col);
    assign y_sum  = {1'b0, pos_y_q} + 11'(row);
    assign a_clip = (x_sum >= 11'(SCREEN_W)) || (y_sum >= 11'(SCREEN_H));
    assign a_dst  = row_base_q + ADDR_W'(pos_x_q) + ADDR_W'(col);

    // Tile base is tile_id*N; with N a power of two this is concatenation.
    assign src_addr = ADDR_W'({tile_q, pix_q});

    // The ROM samples src_addr every edge; a pixel counts as read only on
    // an edge where the output side can still absorb it.
    assign issue = a_valid_q && room;

    assign wr_valid = rd_valid_q && !rd_clip_q && !src_data[TRANSP_BIT];

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and start acceptance.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue && last_pix) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!rd_valid_q && room) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address stage: request latch, pixel walk and incremental row base.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tile_q     <= '0;
            pos_x_q    <= '0;
            pos_y_q    <= '0;
            pix_q      <= '0;
            a_valid_q  <= 1'b0;
            row_base_q <= '0;
        end else if (accept) begin
            tile_q     <= tile_id;
            pos_x_q    <= pos_x;
            pos_y_q    <= pos_y;
            pix_q      <= '0;
            a_valid_q  <= 1'b1;
            row_base_q <= frame_addr({1'b0, pos_y}, 11'd0);
        end else if (issue) begin
            pix_q <= pix_q + 1'b1;
            if (last_pix) begin
                a_valid_q <= 1'b0;
            end
            if (end_of_row) begin
                row_base_q <= row_base_q + ADDR_W'(SCREEN_W);
            end
        end
    end

    // Read stage: destination and clip flag travel alongside the ROM read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_dst_q   <= '0;
            rd_clip_q  <= 1'b0;
        end else begin
            rd_valid_q <= issue;
            if (issue) begin
                rd_dst_q  <= a_dst;
                rd_clip_q <= a_clip;
            end
        end
    end

    blit_skid_reg #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (wr_valid),
        .in_addr   (rd_dst_q),
        .in_data   (src_data),
        .out_ready (dst_ready),
        .out_valid (dst_wr),
        .out_addr  (dst_addr),
        .out_data  (dst_data),
        .room      (room)
    );

endmodule

// File: tb/tb_tile_blitter.sv
// tb_tile_blitter: directed checks of the tile blitter against a
// synchronous ROM model whose word at address a is a[14:0], with bit 15
// optionally set on odd addresses to mark transparent pixels.
module tb_tile_blitter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tile_id = '0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        busy;
    logic        done;
    logic [18:0] src_addr;
    logic [15:0] src_data;
    logic [18:0] dst_addr;
    logic [15:0] dst_data;
    logic        dst_wr;
    logic        dst_ready = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;

    bit transp_mode = 1'b0;

    logic [18:0] log_addr[$];
    logic [15:0] log_data[$];
    int          done_cnt     = 0;
    int          unstable_cnt = 0;
    int          stall_cnt    = 0;
    logic        prev_stall   = 1'b0;
    logic [18:0] prev_addr    = '0;
    logic [15:0] prev_data    = '0;

    always #5 clk = ~clk;

    tile_blitter dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .tile_id   (tile_id),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .done      (done),
        .src_addr  (src_addr),
        .src_data  (src_data),
        .dst_addr  (dst_addr),
        .dst_data  (dst_data),
        .dst_wr    (dst_wr),
        .dst_ready (dst_ready)
    );

    // Synchronous tile ROM model.
    always @(posedge clk) begin
        src_data <= {transp_mode & src_addr[0], src_addr[14:0]};
    end

    // Mid-cycle recorder: accepted writes, done pulses, stalls, stability.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!dst_wr || dst_addr !== prev_addr || dst_data !== prev_data))
                unstable_cnt <= unstable_cnt + 1;
            if (dst_wr && dst_ready) begin
                log_addr.push_back(dst_addr);
                log_data.push_back(dst_data);
            end
            if (dst_wr && !dst_ready) stall_cnt <= stall_cnt + 1;
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= dst_wr && !dst_ready;
            prev_addr  <= dst_addr;
            prev_data  <= dst_data;
        end
    end

    // Starts a blit and waits for done; optionally toggles dst_ready and
    // re-pulses start with different request fields at cycles inj1/inj2.
    task automatic run_blit(input logic [7:0] t, input logic [9:0] x, input logic [9:0] y,
                            input bit bp, input int inj1, input int inj2,
                            output int cyc, output logic [18:0] first_src, output bit to);
        logic [15:0] lfsr;
        lfsr = 16'hACE1;
        cyc = 0;
        to = 1'b0;
        first_src = '0;
        @(posedge clk); #1;
        tile_id = t; pos_x = x; pos_y = y; start = 1'b1;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) first_src = src_addr;
            start = (cyc == inj1) || (cyc == inj2);
            if (start) begin
                tile_id = t ^ 8'h5A;
                pos_x = x + 10'd3;
                pos_y = y + 10'd7;
            end
            if (bp) begin
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                dst_ready = lfsr[0];
            end
            if (done) break;
            if (cyc >= 6000) begin
                to = 1'b1;
                break;
            end
        end
        start = 1'b0;
        dst_ready = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if ({busy, done, dst_wr} !== 3'b000)
            $display("FAIL reset_ctrl: busy/done/dst_wr=%b required 000", {busy, done, dst_wr});
        else n_pass++;
        n_checks++;
        if (src_addr !== 19'd0 || dst_addr !== 19'd0 || dst_data !== 16'd0)
            $display("FAIL reset_data: src_addr=%0d dst_addr=%0d dst_data=%0h required 0/0/0",
                     src_addr, dst_addr, dst_data);
        else n_pass++;
    endtask

    task automatic test_opaque();
        int base, d0, cyc, bad, fb;
        logic [18:0] fs, ea, ga;
        logic [15:0] ed, gd;
        bit to;
        base = log_addr.size(); d0 = done_cnt;
        run_blit(8'd0, 10'd0, 10'd0, 1'b0, 0, 0, cyc, fs, to);
        @(posedge clk); #1;
        n_checks++;
        if (cyc !== 1027) $display("FAIL opaque_latency: %0d cycles required 1027 (timeout=%0d)", cyc, to);
        else n_pass++;
        n_checks++;
        if (log_addr.size() - base !== 1024)
            $display("FAIL opaque_count: %0d writes required 1024", log_addr.size() - base);
        else n_pass++;
        bad = 0; fb = -1; ga = '0; gd = '0; ea = '0; ed = '0;
        for (int k = 0; k < 1024 && base + k < log_addr.size(); k++) begin
            if (log_addr[base+k] !== 19'((k / 32) * 640 + k % 32) || log_data[base+k] !== 16'(k)) begin
                if (bad == 0) begin
                    fb = k; ga = log_addr[base+k]; gd = log_data[base+k];
                    ea = 19'((k / 32) * 640 + k % 32); ed = 16'(k);
                end
                bad++;
            end
        end
        n_checks++;
        if (bad != 0)
            $display("FAIL opaque_writes: %0d wrong, first #%0d addr %0d data %0h required %0d %0h",
                     bad, fb, ga, gd, ea, ed);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL opaque_done: %0d pulses required 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL opaque_after: busy=%b done=%b required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_transparency();
        int base, cyc, bad, fb, k;
        logic [18:0] fs;
        bit to;
        transp_mode = 1'b1;
        base = log_addr.size();
        run_blit(8'd3, 10'd0, 10'd0, 1'b0, 0, 0, cyc, fs, to);
        @(posedge clk); #1;
        transp_mode = 1'b0;
        n_checks++;
        if (fs !== 19'd3072) $display("FAIL transp_src_base: src_addr=%0d required 3072", fs);
        else n_pass++;
        n_checks++;
        if (log_addr.size() - base !== 512)
            $display("FAIL transp_count: %0d writes required 512", log_addr.size() - base);
        else n_pass++;
        bad = 0; fb = -1;
        for (int j = 0; j < 512 && base + j < log_addr.size(); j++) begin
            k = 2 * j;
            if (log_addr[base+j] !== 19'((k / 32) * 640 + k % 32) || log_data[base+j] !== 16'(3072 + k)) begin
                if (bad == 0) fb = j;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL transp_writes: %0d wrong, first at write %0d required 0 wrong", bad, fb);
        else n_pass++;
        n_checks++;
        if (cyc !== 1027) $display("FAIL transp_latency: %0d cycles required 1027", cyc);
        else n_pass++;
    endtask

    task automatic test_clipping();
        int base, cyc, bad, fb, r, c;
        logic [18:0] fs;
        bit to;
        base = log_addr.size();
        run_blit(8'd0, 10'd624, 10'd472, 1'b0, 0, 0, cyc, fs, to);
        @(posedge clk); #1;
        n_checks++;
        if (log_addr.size() - base !== 128)
            $display("FAIL clip_count: %0d writes required 128", log_addr.size() - base);
        else n_pass++;
        n_checks++;
        if (log_addr.size() <= base || log_addr[base] !== 19'd302704)
            $display("FAIL clip_first: first addr %0d required 302704",
                     (log_addr.size() > base) ? log_addr[base] : 19'd0);
        else n_pass++;
        bad = 0; fb = -1;
        for (int j = 0; j < 128 && base + j < log_addr.size(); j++) begin
            r = j / 16; c = j % 16;
            if (log_addr[base+j] !== 19'((472 + r) * 640 + 624 + c) || log_data[base+j] !== 16'(r * 32 + c)) begin
                if (bad == 0) fb = j;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL clip_writes: %0d wrong, first at write %0d required 0 wrong", bad, fb);
        else n_pass++;
        n_checks++;
        if (cyc !== 1027) $display("FAIL clip_done: done after %0d cycles required 1027", cyc);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int base, d0, u0, s0, cyc, bad, fb;
        logic [18:0] fs;
        bit to;
        base = log_addr.size(); d0 = done_cnt; u0 = unstable_cnt; s0 = stall_cnt;
        run_blit(8'd0, 10'd0, 10'd0, 1'b1, 0, 0, cyc, fs, to);
        @(posedge clk); #1;
        n_checks++;
        if (to !== 1'b0) $display("FAIL bp_timeout: done not seen after %0d cycles required done", cyc);
        else n_pass++;
        n_checks++;
        if (log_addr.size() - base !== 1024)
            $display("FAIL bp_count: %0d writes required 1024", log_addr.size() - base);
        else n_pass++;
        bad = 0; fb = -1;
        for (int k = 0; k < 1024 && base + k < log_addr.size(); k++) begin
            if (log_addr[base+k] !== 19'((k / 32) * 640 + k % 32) || log_data[base+k] !== 16'(k)) begin
                if (bad == 0) fb = k;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL bp_order: %0d wrong, first at write %0d required 0 wrong", bad, fb);
        else n_pass++;
        n_checks++;
        if (unstable_cnt - u0 !== 0)
            $display("FAIL bp_stable: %0d outputs changed while stalled required 0", unstable_cnt - u0);
        else n_pass++;
        n_checks++;
        if (stall_cnt - s0 == 0) $display("FAIL bp_stalled: 0 stall cycles observed required >0");
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL bp_done: %0d pulses required 1", done_cnt - d0);
        else n_pass++;
    endtask

    task automatic test_start_ignored();
        int base, d0, cyc, bad, fb;
        logic [18:0] fs;
        bit to;
        base = log_addr.size(); d0 = done_cnt;
        run_blit(8'd5, 10'd64, 10'd32, 1'b0, 5, 40, cyc, fs, to);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (log_addr.size() - base !== 1024)
            $display("FAIL start_ign_count: %0d writes required 1024", log_addr.size() - base);
        else n_pass++;
        bad = 0; fb = -1;
        for (int k = 0; k < 1024 && base + k < log_addr.size(); k++) begin
            if (log_addr[base+k] !== 19'((32 + k / 32) * 640 + 64 + k % 32) || log_data[base+k] !== 16'(5120 + k)) begin
                if (bad == 0) fb = k;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) $display("FAIL start_ign_latch: %0d wrong, first at write %0d required 0 wrong", bad, fb);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 !== 1) $display("FAIL start_ign_done: %0d pulses required 1", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0 || cyc !== 1027)
            $display("FAIL start_ign_idle: busy=%b cycles=%0d required 0 1027", busy, cyc);
        else n_pass++;
    endtask

    task automatic test_reset_abort();
        int base, d0, cyc, nw, bad, fb;
        logic [18:0] fs;
        bit to;
        base = log_addr.size(); d0 = done_cnt;
        @(posedge clk); #1;
        tile_id = 8'd2; pos_x = 10'd0; pos_y = 10'd0; start = 1'b1;
        cyc = 0;
        while (log_addr.size() - base < 300 && cyc < 2000) begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        n_checks++;
        if (log_addr.size() - base < 300)
            $display("FAIL abort_reach: %0d writes before reset required 300", log_addr.size() - base);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, dst_wr} !== 3'b000 || src_addr !== 19'd0 || dst_addr !== 19'd0 || dst_data !== 16'd0)
            $display("FAIL abort_async: busy/done/wr=%b src=%0d dst=%0d data=%0h required all 0",
                     {busy, done, dst_wr}, src_addr, dst_addr, dst_data);
        else n_pass++;
        nw = log_addr.size();
        repeat (4) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt - d0 !== 0) $display("FAIL abort_no_done: %0d pulses required 0", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (log_addr.size() !== nw || dst_wr !== 1'b0)
            $display("FAIL abort_no_write: %0d writes after reset, dst_wr=%b required 0 0",
                     log_addr.size() - nw, dst_wr);
        else n_pass++;
        base = log_addr.size(); d0 = done_cnt;
        run_blit(8'd1, 10'd100, 10'd50, 1'b0, 0, 0, cyc, fs, to);
        @(posedge clk); #1;
        n_checks++;
        if (cyc !== 1027 || done_cnt - d0 !== 1)
            $display("FAIL abort_restart_done: %0d cycles %0d pulses required 1027 1", cyc, done_cnt - d0);
        else n_pass++;
        bad = 0; fb = -1;
        for (int k = 0; k < 1024 && base + k < log_addr.size(); k++) begin
            if (log_addr[base+k] !== 19'((50 + k / 32) * 640 + 100 + k % 32) || log_data[base+k] !== 16'(1024 + k)) begin
                if (bad == 0) fb = k;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0 || log_addr.size() - base !== 1024)
            $display("FAIL abort_restart_writes: %0d writes %0d wrong (first %0d) required 1024 0",
                     log_addr.size() - base, bad, fb);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_opaque();
        test_transparency();
        test_clipping();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
